// File: rtl/pc_next_unit_if.sv
// rtl/pc_next_unit_if.sv - fetch-PC control bundle between pipeline control and the PC unit
interface pc_next_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall_i;
    logic             redirect_i;
    logic [XLEN-1:0]  redirect_pc_i;
    logic             hit_i;
    logic [XLEN-1:0]  target_i;
    logic [XLEN-1:0]  pc_o;
    logic             pc_valid_o;
    logic             flush_o;
    logic             pending_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, hit_i, target_i,
        input  pc_o, pc_valid_o, flush_o, pending_o, redirect_cnt_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, hit_i, target_i,
        output pc_o, pc_valid_o, flush_o, pending_o, redirect_cnt_o
    );
endinterface

// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - next fetch PC selection with stalled-redirect latch, flush bubble and redirect counter
module pc_next_unit #(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned    INC          = 4,
    parameter int unsigned    FLUSH_CYCLES = 2,
    parameter int unsigned    CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_next_unit_if.slave  bus
);
    localparam int unsigned BW = (FLUSH_CYCLES == 0) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
    logic [BW-1:0]    bub_q, bub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oor_q;
    logic             apply_redirect;

    always_comb begin
        pc_d           = pc_q;
        pend_d         = pend_q;
        pend_pc_d      = pend_pc_q;
        bub_d          = bub_q;
        cnt_d          = cnt_q;
        apply_redirect = !bus.stall_i && (bus.redirect_i || pend_q);

        if (!bus.stall_i) begin
            if (bus.redirect_i)  pc_d = bus.redirect_pc_i;
            else if (pend_q)     pc_d = pend_pc_q;
            else if (bus.hit_i)  pc_d = bus.target_i;
            else                 pc_d = pc_q + XLEN'(INC);
            pend_d = 1'b0;
        end else if (bus.redirect_i) begin
            // Only the newest redirect survives a stall.
            pend_d    = 1'b1;
            pend_pc_d = bus.redirect_pc_i;
        end

        if (apply_redirect)   bub_d = BW'(FLUSH_CYCLES);
        else if (bub_q != '0) bub_d = bub_q - 1'b1;

        if (bus.redirect_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VEC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            bub_q     <= '0;
            cnt_q     <= '0;
            oor_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            bub_q     <= bub_d;
            cnt_q     <= cnt_d;
            oor_q     <= 1'b1;
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.flush_o        = (bub_q != '0);
    assign bus.pc_valid_o     = !bus.flush_o && !bus.stall_i && oor_q;
    assign bus.pending_o      = pend_q;
    assign bus.redirect_cnt_o = cnt_q;
endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, giving the PC and address width in bits.
REQ-002 The block SHALL have the parameter RESET_VEC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have the parameter INC, default 4, giving the sequential PC increment.
REQ-004 The block SHALL have the parameter FLUSH_CYCLES, default 2, giving the bubble cycles after each applied redirect (0 means no bubble).
REQ-005 The block SHALL have the parameter CNT_W, default 16, giving the redirect counter width.
REQ-006 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 stall_i  in  1  fetch hold request.
REQ-009 redirect_i  in  1  pipeline flush / mispredict recovery request.
REQ-010 redirect_pc_i  in  XLEN  recovery PC, sampled when redirect_i=1.
REQ-011 hit_i  in  1  branch-buffer predicted-taken hit.
REQ-012 target_i  in  XLEN  predicted target, used when hit_i=1.
REQ-013 pc_o  out  XLEN  registered fetch PC.
REQ-014 pc_valid_o  out  1  pc_o is a valid fetch address this cycle.
REQ-015 flush_o  out  1  redirect bubble in progress.
REQ-016 pending_o  out  1  a redirect is latched awaiting stall release.
REQ-017 redirect_cnt_o  out  CNT_W  count of accepted redirects.

Function
REQ-018 Each edge with rst=0 and stall_i=0, pc_o SHALL load the first true option in this priority order: redirect_i -> redirect_pc_i; pending -> pending PC; hit_i -> target_i; else -> pc_o+INC.
REQ-019 Each edge with rst=0 and stall_i=1, pc_o SHALL hold its value.
REQ-020 The pc_o+INC addition SHALL wrap modulo 2^XLEN with no carry out.
REQ-021 When redirect_i=1 and stall_i=1, the block SHALL latch redirect_pc_i into an internal pending register and set pending_o=1 on the next cycle.
REQ-022 A later redirect that arrives while pending_o=1 and stall_i=1 SHALL overwrite the pending PC; only the newest redirect is kept.
REQ-023 When stall_i=0 and pending_o=1, the block SHALL clear pending_o on that edge, whether the pending PC or a simultaneous redirect_pc_i is the value applied.
REQ-024 hit_i SHALL be ignored on any edge where redirect_i=1 or pending_o=1, or where stall_i=1.
REQ-025 Applying a redirect to pc_o, either direct or from the pending register, SHALL load the bubble counter with FLUSH_CYCLES.
REQ-026 The bubble counter SHALL decrement by 1 each edge while it is nonzero, independent of stall_i, and a new applied redirect SHALL reload it.
REQ-027 flush_o SHALL equal (bubble counter != 0), and pc_valid_o SHALL equal ~flush_o & ~stall_i & out_of_reset.
REQ-028 out_of_reset SHALL be a register that is 0 on reset and 1 on every edge with rst=0.
REQ-029 redirect_cnt_o SHALL increment by 1 on each edge where redirect_i=1, whether the redirect is applied or latched.
REQ-030 redirect_cnt_o SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-031 The bubble counter width SHALL be clog2(FLUSH_CYCLES+1), with a minimum of 1.

Reset
REQ-032 On an edge with rst=1, the block SHALL set pc_o=RESET_VEC, pending_o=0, bubble counter=0, redirect_cnt_o=0 and out_of_reset=0, which gives pc_valid_o=0 and flush_o=0.
REQ-033 rst SHALL override all other inputs, including a redirect arriving in the same cycle or a redirect already latched as pending.
REQ-034 On the first edge after rst falls, normal operation SHALL resume: pc_o=RESET_VEC+INC if no other request is present, and pc_valid_o=1 once out_of_reset=1.

Verification
REQ-035 Sequential: release reset with stall_i, redirect_i and hit_i all 0 -> pc_o reads 0x0, 0x4, 0x8, 0xC on successive cycles, with pc_valid_o=1 from the first cycle after reset.
REQ-036 Predict and redirect priority: with pc_o=0x100, assert hit_i=1, target_i=0x400 together with redirect_i=1, redirect_pc_i=0x200 -> pc_o=0x200, flush_o=1 for 2 cycles with pc_valid_o=0, redirect_cnt_o=1.
REQ-037 Redirect under stall: hold stall_i=1 and pulse redirect 0x300 then redirect 0x500 -> pc_o is unchanged and pending_o=1; release stall -> pc_o=0x500, pending_o=0, redirect_cnt_o=2.
REQ-038 Wrap: with XLEN=32 and pc_o=0xFFFFFFFC, run one sequential step -> pc_o=0x00000000.
REQ-039 Reset mid-operation: assert rst while pending_o=1 and flush_o=1 -> next cycle pc_o=RESET_VEC with all flags and redirect_cnt_o at 0.
REQ-040 Saturation: with CNT_W=2, apply 5 redirects -> redirect_cnt_o=3; with FLUSH_CYCLES=0, a redirect -> flush_o never asserts.
